// File: rtl/popcount_rr_scheduler_if.sv
// Request/response bundle for popcount_rr_scheduler: per-requester valid/ready with packed
// operands, plus a tagged valid/ready result port.
interface popcount_rr_scheduler_if #(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned COUNT_WIDTH = 4,
    parameter int unsigned ID_WIDTH    = 2
);
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_ready;
    logic                          resp_valid;
    logic                          resp_ready;
    logic [ID_WIDTH-1:0]           resp_id;
    logic [COUNT_WIDTH-1:0]        resp_count;

    modport master (
        output req_valid, req_data, resp_ready,
        input  req_ready, resp_valid, resp_id, resp_count
    );

    modport slave (
        input  req_valid, req_data, resp_ready,
        output req_ready, resp_valid, resp_id, resp_count
    );
endinterface

// File: rtl/popcount_rr_scheduler.sv
// Round-robin scheduler sharing one popcount datapath among NUM_REQ requesters.
// Optional stats counters (total_ones, resp_count_total) via POPCOUNT_RR_SCHEDULER_STATS_EN.
module popcount_rr_scheduler #(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned COUNT_WIDTH = 4,
    parameter int unsigned ID_WIDTH    = 2
) (
    input  logic                   clock,
    input  logic                   reset,
    popcount_rr_scheduler_if.slave bus,
    output logic                   busy
`ifdef POPCOUNT_RR_SCHEDULER_STATS_EN
    ,
    output logic [15:0]            total_ones,
    output logic [15:0]            resp_count_total
`endif
);

    typedef enum logic [1:0] {StIdle, StCount, StResp} state_e;

    state_e                 state_q, state_d;
    logic [ID_WIDTH-1:0]    ptr_q, ptr_d;
    logic [ID_WIDTH-1:0]    lat_id_q, lat_id_d;
    logic [DATA_WIDTH-1:0]  operand_q, operand_d;
    logic [ID_WIDTH-1:0]    resp_id_q, resp_id_d;
    logic [COUNT_WIDTH-1:0] resp_count_q, resp_count_d;

    logic                   grant_any;
    logic [ID_WIDTH-1:0]    grant_idx;
    logic [COUNT_WIDTH-1:0] ones;

    // Lowest valid index at or above ptr wins; otherwise lowest valid index below ptr.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        for (int k = int'(NUM_REQ) - 1; k >= 0; k--) begin
            if (bus.req_valid[k] && k < int'(ptr_q)) begin
                grant_any = 1'b1;
                grant_idx = ID_WIDTH'(k);
            end
        end
        for (int k = int'(NUM_REQ) - 1; k >= 0; k--) begin
            if (bus.req_valid[k] && k >= int'(ptr_q)) begin
                grant_any = 1'b1;
                grant_idx = ID_WIDTH'(k);
            end
        end
    end

    always_comb begin
        ones = '0;
        for (int i = 0; i < int'(DATA_WIDTH); i++) begin
            ones = ones + COUNT_WIDTH'(operand_q[i]);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= StIdle;
            ptr_q        <= '0;
            lat_id_q     <= '0;
            operand_q    <= '0;
            resp_id_q    <= '0;
            resp_count_q <= '0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            lat_id_q     <= lat_id_d;
            operand_q    <= operand_d;
            resp_id_q    <= resp_id_d;
            resp_count_q <= resp_count_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        lat_id_d     = lat_id_q;
        operand_d    = operand_q;
        resp_id_d    = resp_id_q;
        resp_count_d = resp_count_q;
        unique case (state_q)
            StIdle: begin
                if (grant_any) begin
                    for (int k = 0; k < int'(NUM_REQ); k++) begin
                        if (grant_idx == ID_WIDTH'(k)) begin
                            operand_d = bus.req_data[k*DATA_WIDTH +: DATA_WIDTH];
                        end
                    end
                    lat_id_d = grant_idx;
                    ptr_d    = (grant_idx == ID_WIDTH'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
                    state_d  = StCount;
                end
            end
            StCount: begin
                resp_count_d = ones;
                resp_id_d    = lat_id_q;
                state_d      = StResp;
            end
            StResp: begin
                if (bus.resp_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        bus.req_ready  = '0;
        bus.resp_valid = 1'b0;
        busy           = 1'b0;
        unique case (state_q)
            StIdle: begin
                for (int k = 0; k < int'(NUM_REQ); k++) begin
                    bus.req_ready[k] = grant_any && (grant_idx == ID_WIDTH'(k));
                end
            end
            StCount: busy = 1'b1;
            StResp: begin
                busy           = 1'b1;
                bus.resp_valid = 1'b1;
            end
            default: busy = 1'b1;
        endcase
    end

    assign bus.resp_id    = resp_id_q;
    assign bus.resp_count = resp_count_q;

`ifdef POPCOUNT_RR_SCHEDULER_STATS_EN
    logic [15:0] total_ones_q, total_ones_d;
    logic [15:0] resp_total_q, resp_total_d;
    logic [16:0] ones_sum;
    logic        accepted;

    always_comb begin
        accepted     = (state_q == StResp) && bus.resp_ready;
        ones_sum     = {1'b0, total_ones_q} + 17'(resp_count_q);
        total_ones_d = total_ones_q;
        resp_total_d = resp_total_q;
        if (accepted) begin
            total_ones_d = ones_sum[16] ? 16'hFFFF : ones_sum[15:0];
            resp_total_d = (resp_total_q == 16'hFFFF) ? resp_total_q : resp_total_q + 16'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            total_ones_q <= '0;
            resp_total_q <= '0;
        end else begin
            total_ones_q <= total_ones_d;
            resp_total_q <= resp_total_d;
        end
    end

    assign total_ones       = total_ones_q;
    assign resp_count_total = resp_total_q;
`endif

endmodule

// File: tb/tb_popcount_rr_scheduler.sv
// Self-checking bench for popcount_rr_scheduler: directed scenarios plus randomized traffic
// against a transaction-level reference model.
module tb_popcount_rr_scheduler;
    localparam int N  = 4;
    localparam int DW = 8;
    localparam int CW = 4;
    localparam int IW = 2;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic busy;
`ifdef POPCOUNT_RR_SCHEDULER_STATS_EN
    logic [15:0] total_ones, resp_count_total;
`endif

    popcount_rr_scheduler_if #(.NUM_REQ(N), .DATA_WIDTH(DW), .COUNT_WIDTH(CW), .ID_WIDTH(IW)) bus();

    popcount_rr_scheduler #(.NUM_REQ(N), .DATA_WIDTH(DW), .COUNT_WIDTH(CW), .ID_WIDTH(IW)) dut (
        .clock            (clock),
        .reset            (reset),
        .bus              (bus),
        .busy             (busy)
`ifdef POPCOUNT_RR_SCHEDULER_STATS_EN
        ,
        .total_ones       (total_ones),
        .resp_count_total (resp_count_total)
`endif
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] data [N];

    // Reference model: phase 0 = waiting for a grant, 1 = computing, 2 = result offered.
    int            m_phase;
    int            m_ptr;
    int            m_lat_id;
    logic [DW-1:0] m_lat_data;
    logic [IW-1:0] m_id;
    logic [CW-1:0] m_cnt;
    int            m_tot;
    int            m_n;

    function automatic void model_reset();
        m_phase = 0; m_ptr = 0; m_lat_id = 0; m_lat_data = '0;
        m_id = '0; m_cnt = '0; m_tot = 0; m_n = 0;
    endfunction

    function automatic int pick(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) begin
            if (v[(m_ptr + i) % N]) return (m_ptr + i) % N;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] exp_ready();
        logic [N-1:0] r;
        int p;
        r = '0;
        p = pick(bus.req_valid);
        if (m_phase == 0 && p >= 0) r[p] = 1'b1;
        return r;
    endfunction

    function automatic void model_edge();
        int p;
        case (m_phase)
            0: begin
                p = pick(bus.req_valid);
                if (p >= 0) begin
                    m_lat_id = p; m_lat_data = data[p]; m_ptr = (p + 1) % N; m_phase = 1;
                end
            end
            1: begin
                m_id = IW'(m_lat_id); m_cnt = CW'($countones(m_lat_data)); m_phase = 2;
            end
            default: begin
                if (bus.resp_ready) begin
                    m_tot = (m_tot + int'(m_cnt) > 65535) ? 65535 : m_tot + int'(m_cnt);
                    m_n   = (m_n == 65535) ? 65535 : m_n + 1;
                    m_phase = 0;
                end
            end
        endcase
    endfunction

    task automatic drive(input logic [N-1:0] v, input logic rr);
        bus.req_valid  = v;
        bus.resp_ready = rr;
        for (int k = 0; k < N; k++) bus.req_data[k*DW +: DW] = data[k];
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic step();
        #2;
        model_edge();
        tick();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        for (int k = 0; k < N; k++) data[k] = 8'hA5;
        drive('1, 1'b0);
        do_reset();
        drive('0, 1'b0);
        #2;
        checks++; if (bus.req_ready !== '0) begin errors++;
            $display("FAIL reset_req_ready: got %b expected 0", bus.req_ready); end
        checks++; if (bus.resp_valid !== 1'b0) begin errors++;
            $display("FAIL reset_resp_valid: got %b expected 0", bus.resp_valid); end
        checks++; if (bus.resp_id !== '0 || bus.resp_count !== '0) begin errors++;
            $display("FAIL reset_resp: got id %0d count %0d expected 0 0", bus.resp_id,
                     bus.resp_count); end
        checks++; if (busy !== 1'b0) begin errors++;
            $display("FAIL reset_busy: got %b expected 0", busy); end
        tick();
    endtask

    task automatic test_single();
        do_reset();
        data[2] = 8'hB5;
        drive(4'b0100, 1'b0);
        #2;
        checks++; if (bus.req_ready !== 4'b0100) begin errors++;
            $display("FAIL single_grant: got %b expected 0100", bus.req_ready); end
        model_edge(); tick();
        drive(4'b0000, 1'b0);
        #2;
        checks++; if (bus.req_ready !== '0 || bus.resp_valid !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL single_count_phase: got ready %b valid %b busy %b expected 0000 0 1",
                     bus.req_ready, bus.resp_valid, busy); end
        model_edge(); tick();
        #2;
        checks++; if (bus.resp_valid !== 1'b1 || bus.resp_id !== 2'd2 || bus.resp_count !== 4'd5)
        begin errors++;
            $display("FAIL single_resp: got valid %b id %0d count %0d expected 1 2 5",
                     bus.resp_valid, bus.resp_id, bus.resp_count); end
        drive(4'b0000, 1'b1);
        model_edge(); tick();
        #2;
        checks++; if (bus.resp_valid !== 1'b0 || busy !== 1'b0) begin errors++;
            $display("FAIL single_done: got valid %b busy %b expected 0 0", bus.resp_valid, busy);
        end
        tick();
    endtask

    task automatic test_round_robin();
        logic [CW-1:0] cnt_tab [N];
        int grants = 0, resps = 0, last = -10;
        cnt_tab = '{4'd0, 4'd1, 4'd2, 4'd8};
        do_reset();
        data = '{8'h00, 8'h01, 8'h03, 8'hFF};
        drive(4'b1111, 1'b1);
        for (int cyc = 0; cyc < 24; cyc++) begin
            #2;
            if (bus.req_ready !== '0) begin
                checks++; if (bus.req_ready !== (4'b0001 << (grants % N))) begin errors++;
                    $display("FAIL rr_order: got %b expected grant %0d", bus.req_ready,
                             grants % N); end
                if (grants > 0) begin
                    checks++; if (cyc - last != 3) begin errors++;
                        $display("FAIL rr_spacing: got %0d expected 3", cyc - last); end
                end
                last = cyc; grants++;
            end
            if (bus.resp_valid === 1'b1) begin
                checks++;
                if (bus.resp_id !== IW'(resps % N) || bus.resp_count !== cnt_tab[resps % N]) begin
                    errors++;
                    $display("FAIL rr_resp: got id %0d count %0d expected %0d %0d", bus.resp_id,
                             bus.resp_count, resps % N, cnt_tab[resps % N]); end
                resps++;
            end
            model_edge(); tick();
        end
        checks++; if (grants != 8) begin errors++;
            $display("FAIL rr_grant_total: got %0d expected 8", grants); end
    endtask

    task automatic test_backpressure();
        do_reset();
        data[1] = 8'h0F;
        drive(4'b0010, 1'b0);
        #2;
        checks++; if (bus.req_ready !== 4'b0010) begin errors++;
            $display("FAIL bp_grant: got %b expected 0010", bus.req_ready); end
        model_edge(); tick();
        data[1] = 8'hFF;
        drive(4'b1111, 1'b0);
        step();
        for (int i = 0; i < 10; i++) begin
            for (int k = 0; k < N; k++) data[k] = DW'($urandom);
            drive(4'b1111, 1'b0);
            #2;
            checks++;
            if (bus.resp_valid !== 1'b1 || bus.resp_id !== 2'd1 || bus.resp_count !== 4'd4 ||
                bus.req_ready !== '0) begin errors++;
                $display("FAIL bp_hold: got valid %b id %0d count %0d ready %b expected 1 1 4 0000",
                         bus.resp_valid, bus.resp_id, bus.resp_count, bus.req_ready); end
            model_edge(); tick();
        end
        drive(4'b1111, 1'b1);
        step();
        #2;
        checks++; if (bus.req_ready !== 4'b0100) begin errors++;
            $display("FAIL bp_next_grant: got %b expected 0100", bus.req_ready); end
        tick();
    endtask

    task automatic test_wrap();
        int seen [$];
        do_reset();
        data[3] = 8'h81; data[0] = 8'h7E;
        drive(4'b1000, 1'b1);
        #2;
        checks++; if (bus.req_ready !== 4'b1000) begin errors++;
            $display("FAIL wrap_first: got %b expected 1000", bus.req_ready); end
        model_edge(); tick();
        drive(4'b1001, 1'b1);
        for (int cyc = 0; cyc < 12 && seen.size() < 2; cyc++) begin
            #2;
            for (int k = 0; k < N; k++) if (bus.req_ready[k] === 1'b1) seen.push_back(k);
            model_edge(); tick();
        end
        checks++; if (seen.size() != 2 || seen[0] != 0 || seen[1] != 3) begin errors++;
            $display("FAIL wrap_order: got %p expected '{0, 3}", seen); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        data[0] = 8'hFF;
        drive(4'b0001, 1'b1); step();
        drive(4'b0000, 1'b1); step(); step(); step();
        drive(4'b0001, 1'b1); step();
        drive(4'b0000, 1'b0);
        reset = 1'b1; tick(); reset = 1'b0; model_reset();
        #2;
        checks++; if (bus.resp_valid !== 1'b0 || busy !== 1'b0 || bus.resp_count !== '0) begin
            errors++;
            $display("FAIL reset_in_count: got valid %b busy %b count %0d expected 0 0 0",
                     bus.resp_valid, busy, bus.resp_count); end
        tick();
        drive(4'b0001, 1'b0); step();
        drive(4'b0000, 1'b0); step();
        #2;
        checks++; if (bus.resp_valid !== 1'b1 || bus.resp_count !== 4'd8) begin errors++;
            $display("FAIL pre_reset_resp: got valid %b count %0d expected 1 8", bus.resp_valid,
                     bus.resp_count); end
        reset = 1'b1; tick(); reset = 1'b0; model_reset();
        drive(4'b0110, 1'b0);
        #2;
        checks++; if (bus.resp_valid !== 1'b0 || busy !== 1'b0 || bus.resp_count !== '0) begin
            errors++;
            $display("FAIL reset_in_resp: got valid %b busy %b count %0d expected 0 0 0",
                     bus.resp_valid, busy, bus.resp_count); end
        checks++; if (bus.req_ready !== 4'b0010) begin errors++;
            $display("FAIL reset_first_grant: got %b expected 0010", bus.req_ready); end
        tick();
    endtask

    task automatic test_random();
        logic [N-1:0] pend;
        int           waitc [N];
        logic [N-1:0] er;
        int           p;
        do_reset();
        pend = '0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            for (int k = 0; k < N; k++) begin
                if (!pend[k] && $urandom_range(2) == 0) begin
                    pend[k] = 1'b1; data[k] = DW'($urandom); waitc[k] = 0;
                end else if (pend[k] && $urandom_range(31) == 0) begin
                    pend[k] = 1'b0;
                end else if (pend[k] && $urandom_range(15) == 0) begin
                    data[k] = DW'($urandom);
                end
            end
            drive(pend, 1'($urandom_range(1)));
            #2;
            er = exp_ready();
            checks++; if (bus.req_ready !== er) begin errors++;
                $display("FAIL rand_ready c%0d: got %b expected %b", cyc, bus.req_ready, er); end
            checks++; if (bus.resp_valid !== (m_phase == 2) || busy !== (m_phase != 0)) begin
                errors++;
                $display("FAIL rand_status c%0d: got valid %b busy %b expected %b %b", cyc,
                         bus.resp_valid, busy, m_phase == 2, m_phase != 0); end
            if (m_phase == 2) begin
                checks++; if (bus.resp_id !== m_id || bus.resp_count !== m_cnt) begin errors++;
                    $display("FAIL rand_resp c%0d: got id %0d count %0d expected %0d %0d", cyc,
                             bus.resp_id, bus.resp_count, m_id, m_cnt); end
            end
            p = (m_phase == 0) ? pick(pend) : -1;
            model_edge();
            if (p >= 0) begin
                checks++; if (waitc[p] > N - 1) begin errors++;
                    $display("FAIL rand_fairness: req %0d waited %0d grants expected <= %0d", p,
                             waitc[p], N - 1); end
                for (int k = 0; k < N; k++) if (pend[k] && k != p) waitc[k]++;
                pend[p] = 1'b0;
            end
            tick();
            if (p >= 0) data[p] = DW'($urandom);
        end
    endtask

`ifdef POPCOUNT_RR_SCHEDULER_STATS_EN
    task automatic test_stats();
        do_reset();
        #2;
        checks++; if (total_ones !== 16'd0 || resp_count_total !== 16'd0) begin errors++;
            $display("FAIL stats_reset: got %0d %0d expected 0 0", total_ones, resp_count_total);
        end
        tick();
        data[3] = 8'hFF;
        drive(4'b1000, 1'b1);
        for (int i = 0; i < 9; i++) step();
        drive(4'b0000, 1'b1);
        step(); step();
        #2;
        checks++; if (total_ones !== 16'd24 || resp_count_total !== 16'd3) begin errors++;
            $display("FAIL stats_sum: got %0d %0d expected 24 3", total_ones, resp_count_total);
        end
        force dut.total_ones_q = 16'hFFF0;
        #1;
        release dut.total_ones_q;
        m_tot = 16'hFFF0;
        tick();
        drive(4'b1000, 1'b1);
        for (int i = 0; i < 9; i++) step();
        drive(4'b0000, 1'b1);
        step(); step();
        #2;
        checks++; if (total_ones !== 16'hFFFF || int'(total_ones) != m_tot) begin errors++;
            $display("FAIL stats_saturate: got %h expected ffff (model %h)", total_ones, m_tot);
        end
        checks++; if (resp_count_total !== 16'd6) begin errors++;
            $display("FAIL stats_count: got %0d expected 6", resp_count_total); end
        tick();
    endtask
`endif

    initial begin
        for (int k = 0; k < N; k++) data[k] = '0;
        drive('0, 1'b0);
        model_reset();
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_wrap();
        test_reset_mid();
        test_random();
`ifdef POPCOUNT_RR_SCHEDULER_STATS_EN
        test_stats();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish within the time limit");
        $fatal(1, "timeout");
    end

endmodule
